// File: rtl/apb_bridge_nslv_if.sv
// Request/response and multi-slave APB signal bundle around apb_bridge_nslv.
// Latency: none, this is wiring only.
// Backpressure: s_ready qualifies transfer; PREADY per slave stretches ACCESS.
// Ports: master = bridge view (takes requests, drives APB, returns responses);
//        slave  = environment view (requester plus the NSLV APB slaves).
interface apb_bridge_nslv_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NSLV   = 4
);
    // requester side
    logic                     transfer;
    logic                     s_ready;
    logic                     SWRITE;
    logic [ADDR_W-1:0]        SADDR;
    logic [DATA_W-1:0]        SWDATA;
    logic [DATA_W/8-1:0]      SSTRB;
    logic [2:0]               SPROT;
    logic                     rsp_valid;
    logic                     rsp_err;
    logic [DATA_W-1:0]        rsp_rdata;
    // APB side
    logic [NSLV-1:0]          PSEL;
    logic                     PENABLE;
    logic                     PWRITE;
    logic [ADDR_W-1:0]        PADDR;
    logic [DATA_W-1:0]        PWDATA;
    logic [DATA_W/8-1:0]      PSTRB;
    logic [2:0]               PPROT;
    logic [NSLV-1:0]          PREADY;
    logic [NSLV-1:0]          PSLVERR;
    logic [NSLV*DATA_W-1:0]   PRDATA;

    modport master (
        input  transfer, SWRITE, SADDR, SWDATA, SSTRB, SPROT,
        input  PREADY, PSLVERR, PRDATA,
        output s_ready, rsp_valid, rsp_err, rsp_rdata,
        output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT
    );

    modport slave (
        output transfer, SWRITE, SADDR, SWDATA, SSTRB, SPROT,
        output PREADY, PSLVERR, PRDATA,
        input  s_ready, rsp_valid, rsp_err, rsp_rdata,
        input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, PPROT
    );
endinterface

// File: rtl/apb_bridge_nslv.sv
// Single-request bridge onto NSLV APB slaves, slave picked by an address region field.
// Latency: accept at edge k, SETUP k+1, ACCESS from k+2, rsp_valid pulse the cycle after completion (best case k+3).
// Backpressure: s_ready only in IDLE; transfer while busy is dropped, PREADY=0 stretches ACCESS up to TIMEOUT cycles.
// Ports: PCLK, PRESETn (synchronous, active-low); bus = apb_bridge_nslv_if.master
//        (transfer/s_ready/S* request, rsp_* response, P* APB fields per slave).
module apb_bridge_nslv #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int NSLV       = 4,
    parameter int REGION_LSB = 12,
    parameter int TIMEOUT    = 16
) (
    input  logic              PCLK,
    input  logic              PRESETn,
    apb_bridge_nslv_if.master bus
);
    localparam int IDX_W = (NSLV > 1) ? $clog2(NSLV) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT);
    localparam logic [IDX_W:0]   NSLV_L  = (IDX_W + 1)'(NSLV);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DERR} state_t;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  idx_q;
    logic [CNT_W-1:0]  cnt_q;

    logic [IDX_W-1:0]  req_idx;
    logic              req_ok;
    logic              accept;
    logic              sel_ready;
    logic              sel_err;
    logic [DATA_W-1:0] sel_rdata;
    logic              timeout_hit;
    logic              done;
    logic              err_nxt;
    logic [DATA_W-1:0] rdata_nxt;
    logic [NSLV-1:0]   psel_oh;

    // Region decode: index must name an existing slave and nothing may sit above the field.
    assign req_idx = bus.SADDR[REGION_LSB +: IDX_W];
    assign req_ok  = ({1'b0, req_idx} < NSLV_L) &&
                     ((bus.SADDR >> (REGION_LSB + IDX_W)) == '0);
    assign accept  = bus.transfer && (state == IDLE);

    // Only the selected slave's response lines are ever looked at.
    assign sel_ready = bus.PREADY[idx_q];
    assign sel_err   = bus.PSLVERR[idx_q];
    assign sel_rdata = bus.PRDATA[idx_q*DATA_W +: DATA_W];

    // cnt_q holds the number of the current ACCESS cycle (1-based).
    assign timeout_hit = (TIMEOUT > 0) && (cnt_q == CNT_MAX);

    always_comb begin
        psel_oh        = '0;
        psel_oh[idx_q] = 1'b1;
    end

    assign bus.s_ready = (state == IDLE);
    assign bus.PENABLE = (state == ACCESS);
    assign bus.PSEL    = ((state == SETUP) || (state == ACCESS)) ? psel_oh : '0;

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        done      = 1'b0;
        err_nxt   = 1'b0;
        rdata_nxt = '0;
        case (state)
            IDLE: begin
                if (bus.transfer) begin
                    state_nxt = req_ok ? SETUP : DERR;
                end
            end
            SETUP: begin
                state_nxt = ACCESS;
            end
            ACCESS: begin
                if (sel_ready) begin
                    done      = 1'b1;
                    err_nxt   = sel_err;
                    rdata_nxt = (bus.PWRITE || sel_err) ? '0 : sel_rdata;
                    state_nxt = IDLE;
                end else if (timeout_hit) begin
                    done      = 1'b1;
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            DERR: begin
                done      = 1'b1;
                err_nxt   = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!PRESETn) begin
            bus.rsp_valid <= 1'b0;
            bus.rsp_err   <= 1'b0;
            bus.rsp_rdata <= '0;
            bus.PWRITE    <= 1'b0;
            bus.PADDR     <= '0;
            bus.PWDATA    <= '0;
            bus.PSTRB     <= '0;
            bus.PPROT     <= '0;
            idx_q         <= '0;
            cnt_q         <= '0;
        end else begin
            // Response is a one-cycle pulse landing in the first IDLE cycle.
            bus.rsp_valid <= done;
            bus.rsp_err   <= err_nxt;
            bus.rsp_rdata <= rdata_nxt;

            // Request fields are frozen at acceptance and stay on the bus until the next one.
            if (accept) begin
                bus.PWRITE <= bus.SWRITE;
                bus.PADDR  <= bus.SADDR;
                bus.PWDATA <= bus.SWDATA;
                bus.PSTRB  <= bus.SWRITE ? bus.SSTRB : '0;
                bus.PPROT  <= bus.SPROT;
                idx_q      <= req_idx;
            end

            if (state == SETUP) begin
                cnt_q <= CNT_ONE;
            end else if ((state == ACCESS) && !done) begin
                cnt_q <= cnt_q + 1'b1;
            end else begin
                cnt_q <= '0;
            end
        end
    end
endmodule

// File: doc/apb_bridge_nslv.md
APB_BRIDGE_NSLV -- requirements
Module: apb_bridge_nslv

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, address width.
REQ-002 SHALL have parameter DATA_W, default 32, data width (multiple of 8).
REQ-003 SHALL have parameter NSLV, default 4, number of APB slaves (1..16).
REQ-004 SHALL have parameter REGION_LSB, default 12, lowest address bit of the slave-index field; index = SADDR[REGION_LSB +: clog2(NSLV)], with a 1-bit field when NSLV=1.
REQ-005 SHALL have parameter TIMEOUT, default 16, maximum ACCESS-phase cycles; 0 disables the timeout.
REQ-006 SHALL have one clock with synchronous, active-low reset: ports PCLK and PRESETn.
REQ-007 PCLK  in  1  clock; all logic rising-edge.
REQ-008 PRESETn  in  1  synchronous active-low reset.
REQ-009 transfer  in  1  request valid.
REQ-010 s_ready  out  1  bridge can accept a request.
REQ-011 SWRITE  in  1  1=write, 0=read.
REQ-012 SADDR  in  ADDR_W  request address.
REQ-013 SWDATA  in  DATA_W  write data.
REQ-014 SSTRB  in  DATA_W/8  write byte strobes.
REQ-015 SPROT  in  3  protection attributes.
REQ-016 rsp_valid  out  1  one-cycle response pulse.
REQ-017 rsp_err  out  1  error response (slave error, decode error or timeout); valid with rsp_valid.
REQ-018 rsp_rdata  out  DATA_W  read data; valid with rsp_valid.
REQ-019 PSEL  out  NSLV  one-hot slave select.
REQ-020 PENABLE, PWRITE  out  1 each  APB enable / direction.
REQ-021 PADDR, PWDATA, PSTRB, PPROT  out  ADDR_W, DATA_W, DATA_W/8, 3  APB request fields.
REQ-022 PREADY, PSLVERR  in  NSLV each  per-slave ready / error.
REQ-023 PRDATA  in  NSLV*DATA_W  per-slave read data; slave i occupies bits [i*DATA_W +: DATA_W].

Function
REQ-024 SHALL implement states IDLE, SETUP, ACCESS, DERR; s_ready=1 only in IDLE.
REQ-025 A request SHALL be accepted on a rising edge where transfer=1 and s_ready=1; SWRITE, SADDR, SWDATA, SSTRB and SPROT SHALL be registered at that edge and held stable on the APB outputs until completion.
REQ-026 On acceptance, if the index is below NSLV and all address bits above the index field are 0, the bridge SHALL go IDLE->SETUP; otherwise IDLE->DERR.
REQ-027 SETUP SHALL last exactly one cycle: the indexed PSEL bit high, PENABLE=0; next state ACCESS.
REQ-028 In ACCESS, PSEL SHALL be held and PENABLE=1; the bridge SHALL sample only the selected slave's PREADY, PSLVERR and PRDATA.
REQ-029 ACCESS SHALL complete on the first edge where the selected PREADY=1, then go to IDLE with PSEL=0 and PENABLE=0.
REQ-030 An ACCESS cycle counter SHALL start at 1 on the first ACCESS cycle; if TIMEOUT>0 and the count reaches TIMEOUT with PREADY=0, the transfer SHALL terminate to IDLE with rsp_err=1.
REQ-031 DERR SHALL last one cycle with all PSEL bits 0 and SHALL then return to IDLE with rsp_err=1; no APB access occurs.
REQ-032 rsp_valid SHALL be a registered pulse in the cycle after completion (the first IDLE cycle); rsp_err = selected PSLVERR at completion, OR decode error, OR timeout.
REQ-033 rsp_rdata SHALL hold the selected PRDATA captured at completion for error-free reads, and 0 for writes and all errors.
REQ-034 PSTRB SHALL be driven to 0 during reads.
REQ-035 Best-case latency SHALL be: accept at edge k, SETUP in cycle k+1, ACCESS in cycle k+2, rsp_valid in cycle k+3; back-to-back requests SHALL be accepted in the rsp_valid cycle.
REQ-036 transfer while s_ready=0 SHALL be ignored and not queued.

Reset
REQ-037 When PRESETn=0 at a rising edge, the bridge SHALL enter IDLE and drive PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0, PSTRB=0, PPROT=0, rsp_valid=0, rsp_err=0, rsp_rdata=0 and counter=0, even mid-transfer; the aborted transfer SHALL produce no response.

Verification
REQ-038 Write addr 0x0000_1004, data 0xDEAD_BEEF, strb 0xF, slave 1 PREADY=1 immediately -> PSEL=4'b0010 for 2 cycles, rsp_valid at k+3, rsp_err=0.
REQ-039 Read addr 0x0000_3000, slave 3 inserts 2 wait states and returns 0x1234_5678 -> ACCESS lasts 3 cycles, PSTRB=0, rsp_rdata=0x1234_5678.
REQ-040 Read addr 0x0001_0000 -> DERR, PSEL never set, rsp_err=1, rsp_rdata=0.
REQ-041 Slave 2 holds PREADY=0, TIMEOUT=16 -> exactly 16 ACCESS cycles, then rsp_err=1.
REQ-042 Slave 0 returns PREADY=1 with PSLVERR=1 on a write -> rsp_err=1; next request accepted in the rsp_valid cycle.
REQ-043 PRESETn=0 during ACCESS -> all outputs reset next edge, and no rsp_valid is produced.
